// File: rtl/bnn_param_loader.sv
// Byte-to-bit-serial loader for the BNN neuron parameter shift chain.
// Optional readback of the displaced chain contents: define BNN_PARAM_READBACK_EN.
module bnn_param_loader #(
  parameter int CHAIN_BITS = 44,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              setup,
  output logic              param_in,
  input  logic              chain_out,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int CNT_W = $clog2(CHAIN_BITS + 1);
  localparam int SH_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bits_rem;
  logic [SH_W-1:0]   grp_bits;
  logic [DATA_W-1:0] shreg;
  logic [SH_W-1:0]   sh_left;
  logic              setup_q;
  logic              param_q;
  logic              accept;
  logic              chain_full;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready never depends on in_valid, and in_valid must hold until accepted.

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (chain_full) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign chain_full = (bit_cnt == CNT_W'(CHAIN_BITS));
  assign accept     = in_valid && in_ready;

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_LOAD: begin
        busy     = 1'b1;
        // Waiting for the last bit to leave param_in gives the one-cycle bubble.
        in_ready = !setup_q && (sh_left == '0) && !chain_full;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Bits the next byte may contribute: a full byte, or the tail of the chain.
  always_comb begin
    bits_rem = CNT_W'(CHAIN_BITS) - bit_cnt;
    if (int'(bits_rem) < DATA_W) begin
      grp_bits = SH_W'(bits_rem);
    end else begin
      grp_bits = SH_W'(DATA_W);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      sh_left <= '0;
      setup_q <= 1'b0;
      param_q <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        bit_cnt <= '0;
      end else if (setup_q) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (accept) begin
        setup_q <= 1'b1;
        param_q <= in_data[DATA_W-1];
        shreg   <= {in_data[DATA_W-2:0], 1'b0};
        sh_left <= grp_bits - SH_W'(1);
      end else if (sh_left != '0) begin
        setup_q <= 1'b1;
        param_q <= shreg[DATA_W-1];
        shreg   <= {shreg[DATA_W-2:0], 1'b0};
        sh_left <= sh_left - SH_W'(1);
      end else begin
        setup_q <= 1'b0;
      end
    end
  end

  assign setup    = setup_q;
  assign param_in = param_q;

`ifdef BNN_PARAM_READBACK_EN
  logic [DATA_W-1:0] cap;
  logic [DATA_W-1:0] cap_nxt;
  logic [SH_W-1:0]   cap_cnt;
  logic              grp_end;
  logic [DATA_W-1:0] rb_data_q;
  logic              rb_valid_q;

  // chain_out is sampled on the same edge the chain shifts, i.e. its pre-shift value.
  always_comb begin
    cap_nxt = cap | ({chain_out, {(DATA_W-1){1'b0}}} >> cap_cnt);
    grp_end = (cap_cnt == SH_W'(DATA_W - 1)) || (bit_cnt == CNT_W'(CHAIN_BITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap        <= '0;
      cap_cnt    <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      if (state == S_IDLE && start) begin
        cap     <= '0;
        cap_cnt <= '0;
      end else if (setup_q) begin
        if (grp_end) begin
          rb_data_q  <= cap_nxt;
          rb_valid_q <= 1'b1;
          cap        <= '0;
          cap_cnt    <= '0;
        end else begin
          cap     <= cap_nxt;
          cap_cnt <= cap_cnt + SH_W'(1);
        end
      end
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_chain_out;
  assign unused_chain_out = chain_out;
  assign rb_data  = '0;
  assign rb_valid = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_param_loader.sv
// Bench for bnn_param_loader: emulates the neuron chain and checks loads against a byte-stream model.
module tb_bnn_param_loader;
  localparam int CB = 44;
  localparam int W  = 8;
  localparam int NB = (CB + W - 1) / W;
  localparam int LB = CB % W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         setup;
  logic         param_in;
  logic         chain_out;
  logic         busy;
  logic         done;
  logic [W-1:0] rb_data;
  logic         rb_valid;

  int checks = 0;
  int errors = 0;

  bnn_param_loader #(.CHAIN_BITS(CB), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .setup(setup),
    .param_in(param_in), .chain_out(chain_out), .busy(busy),
    .done(done), .rb_data(rb_data), .rb_valid(rb_valid)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // neuron chain emulation: bit 0 is the head, bit CB-1 drives chain_out
  logic [CB-1:0] chain_m = 44'h7A5C3C39F01;
  always @(posedge clk) if (setup) chain_m <= {chain_m[CB-2:0], param_in};
  assign chain_out = chain_m[CB-1];

  // monitors, sampled on the falling edge
  int           setup_cnt = 0;
  int           done_cnt = 0;
  int           rb_bad = 0;
  logic [W-1:0] rb_q[$];
  always @(negedge clk) begin
    if (setup === 1'b1) setup_cnt++;
    if (done === 1'b1) done_cnt++;
    if (rb_valid === 1'b1) rb_q.push_back(rb_data);
`ifndef BNN_PARAM_READBACK_EN
    if (rb_valid !== 1'b0 || rb_data !== '0) rb_bad++;
`endif
  end

  // scoreboard
  logic [W-1:0]  pat[NB];
  logic [W-1:0]  exp_q[$];
  logic [CB-1:0] exp_chain;

  task automatic build_expect(input logic [CB-1:0] snap);
    logic [W-1:0] b;
    exp_q.delete();
    for (int g = 0; g < NB; g++) begin
      b = '0;
      for (int j = 0; j < W; j++)
        if (g * W + j < CB) b[W-1-j] = snap[CB-1-(g*W+j)];
      exp_q.push_back(b);
    end
    for (int i = 0; i < CB; i++) exp_chain[CB-1-i] = pat[i/W][W-1-(i%W)];
  endtask

  // driver tasks: all begin and end on a falling edge
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [W-1:0] b);
    int t;
    in_data = b;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_byte_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_chain(input string name, input int stall_idx, input bit start_mid);
    int s0, d0, t;
    logic [CB-1:0] hold;
    build_expect(chain_m);
    rb_q.delete();
    s0 = setup_cnt;
    d0 = done_cnt;
    do_start();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_start: busy=%b in_ready=%b, required 1 1", name, busy, in_ready);
    end
    for (int k = 0; k < NB; k++) begin
      send_byte(pat[k]);
      if (start_mid && k == 2) do_start();
      if (k == stall_idx && k < NB - 1) begin
        while (setup === 1'b1) @(negedge clk);
        hold = chain_m;
        for (int c = 0; c < 5; c++) begin
          checks++;
          if (setup !== 1'b0) begin
            errors++;
            $display("FAIL %s_stall_setup: setup=%b in stall cycle %0d, required 0", name, setup, c);
          end
          if (c < 4) @(negedge clk);
        end
        checks++;
        if (chain_m !== hold) begin
          errors++;
          $display("FAIL %s_stall_hold: chain=%h, required %h", name, chain_m, hold);
        end
      end
    end
    t = 0;
    while (done !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b, required 1 0", name, done, busy);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL %s_done_pulses: %0d, required 1", name, done_cnt - d0);
    end
    checks++;
    if (setup_cnt - s0 != CB) begin
      errors++;
      $display("FAIL %s_setup_cycles: %0d, required %0d", name, setup_cnt - s0, CB);
    end
    checks++;
    if (chain_m !== exp_chain) begin
      errors++;
      $display("FAIL %s_chain: chain=%h, required %h", name, chain_m, exp_chain);
    end
`ifdef BNN_PARAM_READBACK_EN
    checks++;
    if (rb_q.size() != NB) begin
      errors++;
      $display("FAIL %s_rb_count: %0d strobes, required %0d", name, rb_q.size(), NB);
    end else begin
      for (int k = 0; k < NB; k++) begin
        checks++;
        if (rb_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL %s_rb_byte%0d: rb_data=%h, required %h", name, k, rb_q[k], exp_q[k]);
        end
      end
    end
`else
    checks++;
    if (rb_q.size() != 0 || rb_bad != 0) begin
      errors++;
      $display("FAIL %s_rb_off: strobes=%0d bad=%0d, required 0 0", name, rb_q.size(), rb_bad);
    end
`endif
  endtask

  task automatic rand_pat();
    for (int k = 0; k < NB; k++) pat[k] = W'($urandom_range(0, (1 << W) - 1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({setup, param_in, in_ready, busy, done, rb_valid} !== 6'b0 || rb_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: setup=%b param_in=%b in_ready=%b busy=%b done=%b rb_valid=%b rb_data=%h, required all 0",
               setup, param_in, in_ready, busy, done, rb_valid, rb_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || setup !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b in_ready=%b setup=%b, required 0 0 0", busy, in_ready, setup);
    end
  endtask

  task automatic test_basic();
    rand_pat();
    pat[NB-1] = 8'hAB;
    load_chain("basic", -1, 1'b0);
    checks++;
    if (chain_m[3:0] !== 4'b1010) begin
      errors++;
      $display("FAIL basic_last_nibble: head=%b, required 1010", chain_m[3:0]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      rand_pat();
      load_chain("random", -1, 1'b0);
    end
  endtask

  task automatic test_stall();
    rand_pat();
    load_chain("stall", $urandom_range(0, NB - 2), 1'b0);
  endtask

  task automatic test_start_ignored();
    rand_pat();
    load_chain("start_ignored", -1, 1'b1);
  endtask

  task automatic test_reset_mid_load();
    do_start();
    send_byte(8'hFF);
    @(negedge clk);
    checks++;
    if (setup !== 1'b1 || param_in !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: setup=%b param_in=%b, required 1 1", setup, param_in);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({setup, busy, in_ready, param_in} !== 4'b0) begin
      errors++;
      $display("FAIL midreset_drop: setup=%b busy=%b in_ready=%b param_in=%b, required 0000",
               setup, busy, in_ready, param_in);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || setup !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: busy=%b done=%b in_ready=%b setup=%b, required 0000", busy, done, in_ready, setup);
    end
  endtask

  task automatic test_readback();
    logic [W-1:0] a_last;
    logic [W-1:0] m;
    rand_pat();
    pat[NB-1] = 8'hAB;
    a_last = pat[NB-1];
    load_chain("readback_a", -1, 1'b0);
    rand_pat();
    load_chain("readback_b", -1, 1'b0);
    m = '1;
    m = m << (W - LB);
`ifdef BNN_PARAM_READBACK_EN
    checks++;
    if (rb_q.size() != NB || rb_q[rb_q.size()-1] !== (a_last & m)) begin
      errors++;
      $display("FAIL readback_last: strobes=%0d last=%h, required %0d %h",
               rb_q.size(), (rb_q.size() > 0) ? rb_q[rb_q.size()-1] : 8'h00, NB, a_last & m);
    end
`else
    checks++;
    if (rb_q.size() != 0 || rb_data !== '0) begin
      errors++;
      $display("FAIL readback_off: strobes=%0d rb_data=%h mask=%h, required 0 00", rb_q.size(), rb_data, m);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_stall();
    test_start_ignored();
    test_reset_mid_load();
    test_readback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
